// File: rtl/fft_frame_collector.sv
// Serial-to-parallel frame collector: gathers N complex samples from a stream
// and presents them as one parallel frame to a combinational FFT.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   COLLECT | filling buffer at wr_idx, in_ready = 1
//   FULL    | complete frame on frame_out, in_ready follows frame_ready
module fft_frame_collector #(
  parameter int N     = 4,
  parameter int WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic                    in_sof,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] frame_out [N][2],
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_drop,
  output logic [7:0]              drop_count
);

  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic signed [WIDTH-1:0] frame_q [N][2];
  logic                    drop_q;
  logic [7:0]              drop_cnt_q;

  logic                    accept;
  logic                    restart;
  logic [IDX_W-1:0]        wr_addr;

  // A sof arriving mid-frame throws the partial frame away and restarts at entry 0.
  always_comb begin
    accept  = in_valid && in_ready;
    restart = (state_q == COLLECT) && in_sof && (wr_idx_q != '0);
    wr_addr = restart ? '0 : wr_idx_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state and write-index logic; FULL always leaves once the frame is taken.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    if (state_q == FULL && frame_ready) state_d = COLLECT;
    if (accept) begin
      if (restart) begin
        wr_idx_d = IDX_W'(1);
      end else if (wr_idx_q == LAST_IDX) begin
        wr_idx_d = '0;
        state_d  = FULL;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
  end

  // Outputs decoded from state; in_ready passes frame_ready through for zero-bubble handoff.
  always_comb begin
    in_ready    = 1'b1;
    frame_valid = 1'b0;
    if (state_q == FULL) begin
      in_ready    = frame_ready;
      frame_valid = 1'b1;
    end
  end

  // Write index, sample buffer and drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q   <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= 8'd0;
      for (int k = 0; k < N; k++) begin
        frame_q[k][0] <= '0;
        frame_q[k][1] <= '0;
      end
    end else begin
      wr_idx_q <= wr_idx_d;
      drop_q   <= accept && restart;
      if (accept && restart && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (accept) begin
        frame_q[wr_addr][0] <= in_re;
        frame_q[wr_addr][1] <= in_im;
      end
    end
  end

  // The registered buffer drives the FFT inputs directly.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      frame_out[k][0] = frame_q[k][0];
      frame_out[k][1] = frame_q[k][1];
    end
  end

  assign frame_drop = drop_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Self-checking bench for fft_frame_collector: directed scenarios plus
// randomized streaming, compared against a queue-based frame model.
module tb_fft_frame_collector;

  localparam int N     = 4;
  localparam int WIDTH = 12;

  logic                    clk;
  logic                    rst_n;
  logic signed [WIDTH-1:0] in_re;
  logic signed [WIDTH-1:0] in_im;
  logic                    in_sof;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] frame_out [N][2];
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    frame_drop;
  logic [7:0]              drop_count;

  fft_frame_collector #(.N(N), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_re       (in_re),
    .in_im       (in_im),
    .in_sof      (in_sof),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_drop  (frame_drop),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the frame being gathered, last completed frame.
  int m_cur_re[$];
  int m_cur_im[$];
  int m_fr_re [N];
  int m_fr_im [N];
  bit m_full;
  bit m_drop;
  int m_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur_re.delete();
    m_cur_im.delete();
    m_full = 1'b0;
    m_drop = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check_reset_values();
    check("rst_frame_valid", int'(frame_valid), 0);
    check("rst_frame_drop",  int'(frame_drop),  0);
    check("rst_drop_count",  int'(drop_count),  0);
    check("rst_in_ready",    int'(in_ready),    1);
    for (int k = 0; k < N; k++) begin
      check("rst_frame_re", int'(frame_out[k][0]), 0);
      check("rst_frame_im", int'(frame_out[k][1]), 0);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input bit v, input bit sof, input int re, input int im, input bit fr);
    bit exp_ready;
    bit acc;
    @(negedge clk);
    in_valid    = v;
    in_sof      = sof;
    in_re       = WIDTH'(re);
    in_im       = WIDTH'(im);
    frame_ready = fr;
    #1;
    exp_ready = !m_full || fr;
    check("in_ready",    int'(in_ready),    int'(exp_ready));
    check("frame_valid", int'(frame_valid), int'(m_full));
    check("frame_drop",  int'(frame_drop),  int'(m_drop));
    check("drop_count",  int'(drop_count),  m_cnt);
    if (m_full) begin
      for (int k = 0; k < N; k++) begin
        check("frame_re", int'(frame_out[k][0]), m_fr_re[k]);
        check("frame_im", int'(frame_out[k][1]), m_fr_im[k]);
      end
    end
    acc    = v && exp_ready;
    m_drop = 1'b0;
    if (m_full && fr) m_full = 1'b0;
    if (acc) begin
      if (sof && m_cur_re.size() != 0) begin
        m_drop = 1'b1;
        if (m_cnt < 255) m_cnt++;
        m_cur_re.delete();
        m_cur_im.delete();
      end
      m_cur_re.push_back(re);
      m_cur_im.push_back(im);
      if (m_cur_re.size() == N) begin
        for (int k = 0; k < N; k++) begin
          m_fr_re[k] = m_cur_re[k];
          m_fr_im[k] = m_cur_im[k];
        end
        m_cur_re.delete();
        m_cur_im.delete();
        m_full = 1'b1;
      end
    end
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sof      = 1'b0;
    in_re       = '0;
    in_im       = '0;
    frame_ready = 1'b0;
    model_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame streamed back to back.
    for (int i = 1; i <= N; i++) step(1'b1, i == 1, i, -i, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);

    // Frame held with frame_ready low while the source keeps offering data.
    for (int i = 0; i < N; i++) step(1'b1, i == 0, 10 + i, 20 + i, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 99, 99, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);

    // Two frames continuously with frame_ready high.
    for (int i = 0; i < 2 * N; i++) step(1'b1, (i % N) == 0, 100 + i, -100 - i, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);

    // Resynchronising sof after two samples.
    step(1'b1, 1'b1, 1, 1, 1'b1);
    step(1'b1, 1'b0, 2, 2, 1'b1);
    step(1'b1, 1'b1, 7, 7, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 30 + i, -30 - i, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);

    // 300 forced drops to reach saturation.
    step(1'b1, 1'b1, 5, 5, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, i, -i, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);

    // Asynchronous reset after three accepted samples.
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 40 + i, 41 + i, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, 50 + i, -50 - i, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);

    // Randomized streaming with random backpressure and occasional sof.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           rnd_sample(), rnd_sample(), $urandom_range(0, 2) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_collector.md
FFT_FRAME_COLLECTOR -- requirements
Module: fft_frame_collector

Interface
REQ-001 SHALL have parameter N, default 4, samples per frame; power of 2, N >= 2.
REQ-002 SHALL have parameter WIDTH, default 12, signed fixed-point width of each real/imag part.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_re  input  WIDTH signed  real part of streamed sample.
REQ-006 SHALL have port in_im  input  WIDTH signed  imaginary part of streamed sample.
REQ-007 SHALL have port in_sof  input  1  start-of-frame marker qualifying the current sample.
REQ-008 SHALL have port in_valid  input  1  sample present.
REQ-009 SHALL have port in_ready  output  1  collector accepts sample.
REQ-010 SHALL have port frame_out  output  unpacked [N][2] of WIDTH signed  parallel frame; index [k][0]=real, [k][1]=imag of sample k, natural order; drives the combinational fft inputs directly.
REQ-011 SHALL have port frame_valid  output  1  frame_out holds a complete frame.
REQ-012 SHALL have port frame_ready  input  1  downstream consumes frame.
REQ-013 SHALL have port frame_drop  output  1  one-cycle pulse when a partial frame is discarded.
REQ-014 SHALL have port drop_count  output  8  saturating count of discarded partial frames.

Function
REQ-015 Sample accepted iff in_valid && in_ready at a clk edge; frame accepted iff frame_valid && frame_ready.
REQ-016 States: COLLECT (filling buffer), FULL (frame presented); write index wr_idx in 0..N-1.
REQ-017 in_ready SHALL be 1 in COLLECT and equal frame_ready in FULL (combinational pass-through for back-to-back frames); no other combinational input-to-output path.
REQ-018 COLLECT: accepted sample written to buffer entry wr_idx, wr_idx increments; sample at wr_idx = N-1 -> wr_idx wraps to 0, state -> FULL, frame_valid = 1 from the next cycle.
REQ-019 FULL: frame_out and frame_valid held stable while frame_ready = 0; frame_ready = 1 -> frame consumed; if no sample accepted in that cycle -> COLLECT, frame_valid = 0 next cycle.
REQ-020 FULL with frame_ready = 1 and sample accepted in the same cycle: sample written to entry 0, wr_idx = 1, state -> COLLECT; zero bubble between frames.
REQ-021 in_sof = 1 on accepted sample while wr_idx != 0 in COLLECT: partial frame discarded, sample written to entry 0, wr_idx = 1, frame_drop = 1 next cycle for one cycle, drop_count += 1 saturating at 255.
REQ-022 in_sof = 1 with wr_idx = 0 (incl. REQ-020 case) is a normal frame start, no drop; in_sof = 0 with wr_idx = 0 accepted as sample 0 (sof only resynchronises).
REQ-023 Entries not yet rewritten keep old values; frame_out contents undefined-by-contract while frame_valid = 0 but SHALL be the registered buffer (no X).
REQ-024 Data stored bit-exact; no arithmetic, scaling, or reordering.
REQ-025 Latency: last sample accepted at edge t -> frame_valid = 1 after edge t; frame of N samples needs minimum N cycles; sustained throughput one sample/cycle with frame_ready held 1.

Reset
REQ-026 rst_n = 0 SHALL immediately force: state COLLECT, wr_idx 0, frame_valid 0, frame_drop 0, drop_count 0, all frame_out entries 0; in_ready = 1 once rst_n = 1.
REQ-027 Reset mid-frame or while FULL SHALL discard buffered samples without frame_drop pulse or drop_count increment.

Verification (N=4, WIDTH=12)
REQ-028 Stream (1,-1),(2,-2),(3,-3),(4,-4) back-to-back, frame_ready=1 -> frame_valid one cycle after 4th acceptance, frame_out[0..3] = those values in order.
REQ-029 Complete frame, frame_ready=0 for 5 cycles -> frame_valid and frame_out stable, in_ready=0, no sample accepted; frame_ready=1 -> frame consumed, in_ready=1.
REQ-030 Two frames streamed continuously with frame_ready=1 -> in_ready never drops, second frame's sample 0 lands in entry 0, both frames correct.
REQ-031 Accept 2 samples, then sample (7,7) with in_sof=1, then 3 more -> one frame_drop pulse, drop_count=1, frame_out[0]=(7,7).
REQ-032 300 forced drops -> drop_count saturates at 255.
REQ-033 Assert rst_n=0 after 3 samples accepted -> all outputs at REQ-026 values asynchronously; next frame of 4 samples collected correctly, drop_count=0.
